// File: rtl/vmem_burst_responder_pkg.sv
// Shared video-memory bus definitions: address/data widths, burst defaults,
// responder state encoding and packed payloads for the memory request and
// the returned data beat.
package vmem_burst_responder_pkg;

  localparam int unsigned BYTE_ADDR_W         = 22;
  localparam int unsigned WORD_ADDR_W         = BYTE_ADDR_W - 1;
  localparam int unsigned DATA_W              = 16;
  localparam int unsigned BURST_WORDS_DEFAULT = 4;
  // Wide enough to count 0..BURST_WORDS for the supported burst length.
  localparam int unsigned BURST_CNT_W         = 3;

  typedef logic [WORD_ADDR_W-1:0] word_addr_t;
  typedef logic [DATA_W-1:0]      data_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } vmem_state_e;

  // Read request toward the memory.
  typedef struct packed {
    logic       rd;
    word_addr_t addr;
  } mem_req_t;

  // Data beat toward the display-control master; last marks bus_ack.
  typedef struct packed {
    logic  valid;
    logic  last;
    data_t data;
  } burst_beat_t;

  // Word address of beat idx within a burst; wraps within the word space.
  function automatic word_addr_t burst_word_addr(input word_addr_t base,
                                                 input logic [BURST_CNT_W-1:0] idx);
    return base + word_addr_t'(idx);
  endfunction

endpackage

// File: rtl/vmem_burst_responder.sv
// Burst read responder: turns one address-strobe request from a display
// master into BURST_WORDS pipelined word reads on the memory side and
// forwards the returned words, flagging the last one with bus_ack.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   address, as       byte address and request strobe from the master
//   din               returned data word (held when burstdata_valid=0)
//   burstdata_valid   din valid this cycle
//   bus_ack           burst complete, coincides with the final word
//   mem_addr, mem_rd  word-address read request, taken when mem_ready=1
//   mem_ready         memory accepts the request
//   mem_rvalid/rdata  in-order read return
module vmem_burst_responder
  import vmem_burst_responder_pkg::*;
#(
  parameter int unsigned BURST_WORDS     = BURST_WORDS_DEFAULT,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [BYTE_ADDR_W-1:0] address,
  input  logic                   as,
  output logic [DATA_W-1:0]      din,
  output logic                   burstdata_valid,
  output logic                   bus_ack,
  output logic [WORD_ADDR_W-1:0] mem_addr,
  output logic                   mem_rd,
  input  logic                   mem_ready,
  input  logic                   mem_rvalid,
  input  logic [DATA_W-1:0]      mem_rdata
);

  localparam logic [BURST_CNT_W-1:0] LAST_IDX = BURST_CNT_W'(BURST_WORDS - 1);
  localparam logic [BURST_CNT_W-1:0] MAX_OUT  = BURST_CNT_W'(MAX_OUTSTANDING);

  vmem_state_e            state_q, state_d;
  word_addr_t             base_q, base_d;
  logic [BURST_CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [BURST_CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  mem_req_t               req_q, req_d;
  burst_beat_t            beat_q, beat_d;
  logic                   issue_fire;
  logic                   ret_fire;
  logic                   unused_addr_lsb;

  // Byte lane select is meaningless for a word-wide read.
  assign unused_addr_lsb = address[0];

  assign mem_rd          = req_q.rd;
  assign mem_addr        = req_q.addr;
  assign din             = beat_q.data;
  assign burstdata_valid = beat_q.valid;
  assign bus_ack         = beat_q.last;

  // State and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      req_q       <= '0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      req_q       <= req_d;
      beat_q      <= beat_d;
    end
  end

  // Next state, counters and next values of the output registers.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    beat_d      = '{valid: 1'b0, last: 1'b0, data: beat_q.data};
    req_d       = '{rd: 1'b0, addr: req_q.addr};

    issue_fire  = (state_q == ST_ISSUE) && req_q.rd && mem_ready;
    // Returns with no burst open (including after a mid-burst reset) are dropped.
    ret_fire    = mem_rvalid && (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        // The bus_ack cycle is already IDLE; a strobe still held from the
        // finished burst must not start another one.
        if (as && !bus_ack) begin
          state_d     = ST_ISSUE;
          base_d      = address[BYTE_ADDR_W-1:1];
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
        end
      end
      ST_ISSUE: begin
        if (issue_fire) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
      end
      default: state_d = ST_IDLE;
    endcase

    if (ret_fire) begin
      beat_d.valid = 1'b1;
      beat_d.data  = mem_rdata;
      ret_cnt_d    = ret_cnt_q + 1'b1;
      if (ret_cnt_q == LAST_IDX) begin
        beat_d.last = 1'b1;
        state_d     = ST_IDLE;
      end
    end

    // Request is registered, so throttle on next-cycle outstanding count.
    if (state_d == ST_ISSUE) begin
      req_d.rd   = (issue_cnt_d - ret_cnt_d) < MAX_OUT;
      req_d.addr = burst_word_addr(base_d, issue_cnt_d);
    end
  end

`ifndef SYNTHESIS
  // Read data with no burst open points at a memory-side protocol problem.
  always @(posedge clk) begin
    if (reset_n && mem_rvalid && (state_q == ST_IDLE))
      $warning("vmem_burst_responder: read return with no open burst, word dropped");
  end
`endif

endmodule

// File: tb/tb_vmem_burst_responder.sv
module tb_vmem_burst_responder;

  localparam int unsigned MAX_OUT = 2;

  logic        clk;
  logic        reset_n;
  logic [21:0] address;
  logic        as;
  logic [15:0] din;
  logic        burstdata_valid;
  logic        bus_ack;
  logic [20:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;

  vmem_burst_responder #(.BURST_WORDS(4), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .as(as),
    .din(din), .burstdata_valid(burstdata_valid), .bus_ack(bus_ack),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: in-order returns, latency fixed or from a table.
  int         rq_due[$];
  logic [15:0] rq_data[$];
  int         last_due = 0;
  int         acc_idx = 0;
  int         max_out = 0;
  int         ready_mode = 0;
  int         lat_mode = 0;
  int         lat_fixed = 2;
  int         lat_tab[8] = '{1, 5, 2, 4, 3, 1, 5, 2};
  logic [3:0] ready_pat = 4'b1001;   // cycles mod 4: 1,0,0,1

  // Logs of accepted requests and delivered words.
  logic [20:0] iss_addr[$];
  int          iss_cyc[$];
  logic [15:0] out_data[$];
  logic        out_ack[$];
  logic [15:0] prev_din = '0;

  function automatic logic [15:0] mem_word(input logic [20:0] a);
    return a[15:0] ^ 16'h5A00;
  endfunction

  always @(negedge clk) begin
    int lat;
    int due;
    mem_rvalid = 1'b0;
    if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rq_data[0];
      void'(rq_due.pop_front());
      void'(rq_data.pop_front());
    end
    mem_ready = (ready_mode == 0) ? 1'b1 : ready_pat[cyc[1:0]];
    if (reset_n && mem_rd && mem_ready) begin
      lat = (lat_mode == 0) ? lat_fixed : lat_tab[acc_idx % 8];
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      acc_idx++;
      rq_due.push_back(due);
      rq_data.push_back(mem_word(mem_addr));
      iss_addr.push_back(mem_addr);
      iss_cyc.push_back(cyc);
      if (rq_due.size() > max_out) max_out = rq_due.size();
      chk("outstanding_le_max", 32'(rq_due.size() <= int'(MAX_OUT)), 32'd1);
    end
  end

  always @(negedge clk) begin
    if (burstdata_valid) begin
      out_data.push_back(din);
      out_ack.push_back(bus_ack);
    end
    if (reset_n) begin
      chk("ack_without_word", 32'(bus_ack && !burstdata_valid), 32'd0);
      if (!burstdata_valid) chk("din_hold", 32'(din), 32'(prev_din));
    end
    prev_din = din;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iss_addr.delete();
    iss_cyc.delete();
    out_data.delete();
    out_ack.delete();
    max_out = 0;
  endtask

  task automatic wait_ack(input string tag, output int ack_cyc);
    ack_cyc = -1;
    for (int n = 0; n < 200 && ack_cyc < 0; n++) begin
      step();
      if (bus_ack) ack_cyc = cyc;
    end
    chk(tag, 32'(ack_cyc >= 0), 32'd1);
  endtask

  task automatic wait_words(input string tag, input int k);
    int n = 0;
    while (out_data.size() < k && n < 200) begin
      step();
      n++;
    end
    chk(tag, 32'(out_data.size() >= k), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (rq_due.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk(tag, 32'(rq_due.size()), 32'd0);
  endtask

  task automatic check_burst(input string tag, input logic [20:0] ea[4], input logic [15:0] ed[4]);
    chk({tag, "_n_issued"}, 32'(iss_addr.size()), 32'd4);
    chk({tag, "_n_words"}, 32'(out_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_addr%0d", tag, i),
          (i < iss_addr.size()) ? 32'(iss_addr[i]) : 32'bx, 32'(ea[i]));
      chk($sformatf("%s_data%0d", tag, i),
          (i < out_data.size()) ? 32'(out_data[i]) : 32'bx, 32'(ed[i]));
      chk($sformatf("%s_ack%0d", tag, i),
          (i < out_ack.size()) ? 32'(out_ack[i]) : 32'bx, (i == 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ack_c;
    int n_iss;
    reset_n    = 1'b0;
    mem_ready  = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    // Request already pending while in reset; must be taken on the first edge.
    as         = 1'b1;
    address    = 22'h000400;

    repeat (3) step();
    chk("rst_valid", 32'(burstdata_valid), 32'd0);
    chk("rst_ack", 32'(bus_ack), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);

    // Single burst, fixed latency 2, strobe held through the bus_ack edge.
    clear_logs();
    lat_fixed = 2;
    reset_n = 1'b1;
    step();
    chk("first_edge_mem_rd", 32'(mem_rd), 32'd1);
    chk("first_edge_mem_addr", 32'(mem_addr), 32'h200);
    wait_ack("s1_ack_seen", ack_c);
    step();
    as = 1'b0;
    repeat (6) step();
    check_burst("s1", '{21'h200, 21'h201, 21'h202, 21'h203},
                '{16'h5800, 16'h5801, 16'h5802, 16'h5803});
    if (iss_cyc.size() == 4) begin
      chk("s1_issue_gap1", 32'(iss_cyc[1] - iss_cyc[0]), 32'd1);
      chk("s1_issue_gap2", 32'(iss_cyc[2] - iss_cyc[0]), 32'd3);
      chk("s1_issue_gap3", 32'(iss_cyc[3] - iss_cyc[0]), 32'd4);
      chk("s1_ack_latency", 32'(ack_c - iss_cyc[0]), 32'd7);
    end
    chk("s1_max_outstanding", 32'(max_out), 32'd2);

    // Chaining: new address presented the cycle after bus_ack.
    clear_logs();
    lat_fixed = 1;
    as = 1'b1;
    address = 22'h000008;
    wait_ack("s2a_ack_seen", ack_c);
    step();
    address = 22'h001008;
    clear_logs();
    wait_ack("s2b_ack_seen", n_iss);
    step();
    as = 1'b0;
    repeat (4) step();
    check_burst("s2", '{21'h804, 21'h805, 21'h806, 21'h807},
                '{16'h5204, 16'h5205, 16'h5206, 16'h5207});
    chk("s2_no_lost_cycle", (iss_cyc.size() > 0) ? 32'(iss_cyc[0]) : 32'bx, 32'(ack_c + 2));

    // mem_ready 1,0,0,1 and variable return latency; odd byte address.
    clear_logs();
    ready_mode = 1;
    lat_mode = 1;
    acc_idx = 0;
    as = 1'b1;
    address = 22'h0000AD;
    wait_ack("s3_ack_seen", ack_c);
    as = 1'b0;
    repeat (8) step();
    check_burst("s3", '{21'h056, 21'h057, 21'h058, 21'h059},
                '{16'h5A56, 16'h5A57, 16'h5A58, 16'h5A59});
    ready_mode = 0;
    lat_mode = 0;

    // Word-address wrap.
    clear_logs();
    lat_fixed = 1;
    as = 1'b1;
    address = 22'h3FFFFC;
    wait_ack("s4_ack_seen", ack_c);
    as = 1'b0;
    repeat (4) step();
    check_burst("s4", '{21'h1FFFFE, 21'h1FFFFF, 21'h000000, 21'h000001},
                '{16'hA5FE, 16'hA5FF, 16'h5A00, 16'h5A01});

    // Reset after word 2; late returns dropped; then a clean burst.
    clear_logs();
    lat_fixed = 3;
    as = 1'b1;
    address = 22'h000400;
    wait_words("s5_two_words", 2);
    reset_n = 1'b0;
    as = 1'b0;
    #1;
    chk("s5_rst_valid", 32'(burstdata_valid), 32'd0);
    chk("s5_rst_ack", 32'(bus_ack), 32'd0);
    chk("s5_rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("s5_rst_din", 32'(din), 32'd0);
    chk("s5_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("s5_pending_at_reset", 32'(rq_due.size()), 32'd2);
    n_iss = iss_addr.size();
    step();
    reset_n = 1'b1;
    wait_drain("s5_drain");
    repeat (2) step();
    chk("s5_late_dropped", 32'(out_data.size()), 32'd2);
    chk("s5_no_new_issue", 32'(iss_addr.size()), 32'(n_iss));
    clear_logs();
    as = 1'b1;
    address = 22'h000404;
    wait_ack("s5_ack_seen", ack_c);
    as = 1'b0;
    repeat (6) step();
    check_burst("s5", '{21'h202, 21'h203, 21'h204, 21'h205},
                '{16'h5802, 16'h5803, 16'h5804, 16'h5805});

    // Master that only consumes two words, then waits for bus_ack.
    clear_logs();
    lat_fixed = 1;
    as = 1'b1;
    address = 22'h000010;
    wait_words("s6_two_words", 2);
    wait_ack("s6_ack_seen", ack_c);
    as = 1'b0;
    repeat (5) step();
    chk("s6_idle_mem_rd", 32'(mem_rd), 32'd0);
    chk("s6_idle_valid", 32'(burstdata_valid), 32'd0);
    check_burst("s6", '{21'h008, 21'h009, 21'h00A, 21'h00B},
                '{16'h5A08, 16'h5A09, 16'h5A0A, 16'h5A0B});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
